// File: rtl/stage_mem_pkg.sv
// stage_mem_pkg: shared encodings for the MEM pipeline stage.
//   - load-type codes carried on memCtrl
//   - write-back source codes carried on wbSrc
//   - MEM stage FSM state encoding
package stage_mem_pkg;

  // Load types. 3'b111 is reserved and behaves as lw.
  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LWL = 3'b010;
  localparam logic [2:0] LT_LW  = 3'b011;
  localparam logic [2:0] LT_LBU = 3'b100;
  localparam logic [2:0] LT_LHU = 3'b101;
  localparam logic [2:0] LT_LWR = 3'b110;

  // Write-back sources. 3'b101..3'b111 select the ALU result.
  localparam logic [2:0] WB_ALU  = 3'b000;
  localparam logic [2:0] WB_LOAD = 3'b001;
  localparam logic [2:0] WB_HI   = 3'b010;
  localparam logic [2:0] WB_LO   = 3'b011;
  localparam logic [2:0] WB_PC8  = 3'b100;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/stage_mem_if.sv
// stage_mem_if: EX->MEM pipeline inputs, data-memory handshake and
// MEM->WB outputs of the MEM stage.
//   master : EX / data memory / WB side (drives the stage inputs)
//   slave  : the MEM stage itself
// Signals:
//   stallIn, flush                      pipeline control into MEM
//   aluIn, hiIn, loIn, rtIn, pcIn       EX datapath values
//   memCtrlIn, wbRegIn, wbSrcIn         EX control values
//   isLoad, isStore, instValidIn        EX request / valid
//   memAck, memRData                    data-memory completion
//   wbData, wbReg, wbEn                 write-back to the register file
//   stallOut, pcOut, instValidOut       stall to IF/ID/EX, PC/valid onward
interface stage_mem_if;
  logic        stallIn;
  logic        flush;
  logic [31:0] aluIn;
  logic [31:0] hiIn;
  logic [31:0] loIn;
  logic [31:0] rtIn;
  logic [2:0]  memCtrlIn;
  logic        isLoad;
  logic        isStore;
  logic [4:0]  wbRegIn;
  logic [2:0]  wbSrcIn;
  logic [31:0] pcIn;
  logic        instValidIn;
  logic        memAck;
  logic [31:0] memRData;
  logic [31:0] wbData;
  logic [4:0]  wbReg;
  logic        wbEn;
  logic        stallOut;
  logic [31:0] pcOut;
  logic        instValidOut;

  modport master (
    output stallIn, flush, aluIn, hiIn, loIn, rtIn, memCtrlIn, isLoad, isStore,
           wbRegIn, wbSrcIn, pcIn, instValidIn, memAck, memRData,
    input  wbData, wbReg, wbEn, stallOut, pcOut, instValidOut
  );

  modport slave (
    input  stallIn, flush, aluIn, hiIn, loIn, rtIn, memCtrlIn, isLoad, isStore,
           wbRegIn, wbSrcIn, pcIn, instValidIn, memAck, memRData,
    output wbData, wbReg, wbEn, stallOut, pcOut, instValidOut
  );
endinterface

// File: rtl/stage_mem_load_align.sv
// stage_mem_load_align: purely combinational load alignment.
//   mem_ctrl : load type
//   ofs      : address byte offset
//   mem_word : word-aligned memory read data
//   rt       : old rt value, merged in by lwl/lwr
//   data     : aligned / extended result
module stage_mem_load_align
  import stage_mem_pkg::*;
(
  input  logic [2:0]  mem_ctrl,
  input  logic [1:0]  ofs,
  input  logic [31:0] mem_word,
  input  logic [31:0] rt,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (ofs)
      2'd0:    byte_sel = mem_word[7:0];
      2'd1:    byte_sel = mem_word[15:8];
      2'd2:    byte_sel = mem_word[23:16];
      default: byte_sel = mem_word[31:24];
    endcase
    half_sel = ofs[1] ? mem_word[31:16] : mem_word[15:0];

    case (mem_ctrl)
      LT_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      LT_LBU: data = {24'd0, byte_sel};
      LT_LH:  data = {{16{half_sel[15]}}, half_sel};
      LT_LHU: data = {16'd0, half_sel};
      LT_LWL: begin
        case (ofs)
          2'd0:    data = {mem_word[7:0],  rt[23:0]};
          2'd1:    data = {mem_word[15:0], rt[15:0]};
          2'd2:    data = {mem_word[23:0], rt[7:0]};
          default: data = mem_word;
        endcase
      end
      LT_LWR: begin
        case (ofs)
          2'd0:    data = mem_word;
          2'd1:    data = {rt[31:24], mem_word[31:8]};
          2'd2:    data = {rt[31:16], mem_word[31:16]};
          default: data = {rt[31:8],  mem_word[31:24]};
        endcase
      end
      default: data = mem_word;  // lw and reserved code
    endcase
  end

endmodule

// File: rtl/stage_mem.sv
// stage_mem: MEM stage of the 5-stage pipeline.
// Registers EX results, waits out the data-memory handshake, aligns load
// data and selects the single write-back value for WB.
//   clk, rst_n : pipeline clock, synchronous active-low reset
//   bus        : stage_mem_if slave (EX inputs, memory handshake, WB outputs)
module stage_mem
  import stage_mem_pkg::*;
(
  input logic        clk,
  input logic        rst_n,
  stage_mem_if.slave bus
);

  state_e      state_q, state_d;
  logic [31:0] alu_q, alu_d, hi_q, hi_d, lo_q, lo_d, rt_q, rt_d, pc_q, pc_d;
  logic [31:0] rdata_hold_q, rdata_hold_d;
  logic [2:0]  mem_ctrl_q, mem_ctrl_d, wb_src_q, wb_src_d;
  logic [4:0]  wb_reg_q, wb_reg_d;
  logic        valid_q, valid_d, mem_req_q, mem_req_d;
  logic        stall, advance;
  logic [31:0] align_word, load_data;

  always_comb begin
    stall = ~bus.memAck & ((state_q == ST_WAIT) | ((state_q == ST_RUN) & mem_req_q));
    // The ack cycle in WAIT only captures the read word; the instruction
    // retires from DONE, so nothing is captured while in WAIT.
    advance = ~bus.stallIn & ~stall & (state_q != ST_WAIT);
  end

  always_comb begin
    state_d      = state_q;
    rdata_hold_d = rdata_hold_q;
    alu_d        = alu_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    rt_d         = rt_q;
    pc_d         = pc_q;
    mem_ctrl_d   = mem_ctrl_q;
    wb_src_d     = wb_src_q;
    wb_reg_d     = wb_reg_q;
    valid_d      = valid_q;
    mem_req_d    = mem_req_q;

    case (state_q)
      ST_RUN: begin
        if (mem_req_q) begin
          if (!bus.memAck) begin
            state_d = ST_WAIT;
          end else if (bus.stallIn) begin
            // Same-cycle ack but held downstream: keep the word for later.
            state_d      = ST_DONE;
            rdata_hold_d = bus.memRData;
          end
        end
      end
      ST_WAIT: begin
        if (bus.memAck) begin
          state_d      = ST_DONE;
          rdata_hold_d = bus.memRData;
        end
      end
      ST_DONE: begin
        if (!bus.stallIn) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase

    if (advance) begin
      alu_d = bus.aluIn;
      hi_d  = bus.hiIn;
      lo_d  = bus.loIn;
      rt_d  = bus.rtIn;
      pc_d  = bus.pcIn;
      if (bus.flush) begin
        valid_d    = 1'b0;
        wb_reg_d   = 5'd0;
        mem_req_d  = 1'b0;
        mem_ctrl_d = LT_LW;
        wb_src_d   = WB_ALU;
      end else begin
        valid_d    = bus.instValidIn;
        wb_reg_d   = bus.wbRegIn;
        mem_req_d  = bus.isLoad | bus.isStore;
        mem_ctrl_d = bus.memCtrlIn;
        wb_src_d   = bus.wbSrcIn;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      rdata_hold_q <= 32'd0;
      alu_q        <= 32'd0;
      hi_q         <= 32'd0;
      lo_q         <= 32'd0;
      rt_q         <= 32'd0;
      pc_q         <= 32'd0;
      mem_ctrl_q   <= LT_LW;
      wb_src_q     <= WB_ALU;
      wb_reg_q     <= 5'd0;
      valid_q      <= 1'b0;
      mem_req_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rdata_hold_q <= rdata_hold_d;
      alu_q        <= alu_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      rt_q         <= rt_d;
      pc_q         <= pc_d;
      mem_ctrl_q   <= mem_ctrl_d;
      wb_src_q     <= wb_src_d;
      wb_reg_q     <= wb_reg_d;
      valid_q      <= valid_d;
      mem_req_q    <= mem_req_d;
    end
  end

  assign align_word = (state_q == ST_DONE) ? rdata_hold_q : bus.memRData;

  stage_mem_load_align u_align (
    .mem_ctrl (mem_ctrl_q),
    .ofs      (alu_q[1:0]),
    .mem_word (align_word),
    .rt       (rt_q),
    .data     (load_data)
  );

  always_comb begin
    case (wb_src_q)
      WB_LOAD: bus.wbData = load_data;
      WB_HI:   bus.wbData = hi_q;
      WB_LO:   bus.wbData = lo_q;
      WB_PC8:  bus.wbData = pc_q + 32'd8;
      default: bus.wbData = alu_q;
    endcase
    bus.wbReg        = wb_reg_q;
    bus.wbEn         = valid_q & (wb_reg_q != 5'd0) &
                       ((state_q == ST_RUN) | (state_q == ST_DONE));
    bus.stallOut     = stall;
    bus.pcOut        = pc_q;
    bus.instValidOut = valid_q;
  end

endmodule

// File: doc/stage_mem.md
# stage_mem

MEM stage of the 5-stage CPU pipeline. It sits between EX and WB and registers EX results (ALU output, HI/LO, load type, destination register, write-back source). It waits for the data-memory handshake on loads and stores, then aligns and sign-extends load data, including the lwl/lwr merge with the old rt value. It produces the single write-back value and the register-file write enable for WB, and raises a stall to the upstream stages while a memory access is outstanding.

## Interface
Parameters:
- none; load-type and write-back-source encodings live in `cpu_defs`.

Ports:
- `clk` in 1: pipeline clock. One clock; reset is synchronous and active-low.
- `rst_n` in 1: synchronous active-low reset.
- `stallIn` in 1: downstream or global stall; hold all registers.
- `flush` in 1: squash the instruction entering this stage (acts like reset on control registers).
- `aluIn` in 32: EX ALU result; also the memory address.
- `hiIn`, `loIn` in 32 each: HI/LO values from MulDiv.
- `rtIn` in 32: forwarded rt value, used for the lwl/lwr merge.
- `memCtrlIn` in 3: load type from EX.
- `isLoad`, `isStore` in 1 each: EX issued a memory read or write this cycle (EX `memReq` split by direction).
- `wbRegIn` in 5: destination register; 0 means no write.
- `wbSrcIn` in 3: write-back source select.
- `pcIn` in 32: instruction PC.
- `instValidIn` in 1: instruction valid.
- `memAck` in 1: data memory completes the access (read data valid for loads).
- `memRData` in 32: read data, word-aligned.
- `wbData` out 32: value to write back.
- `wbReg` out 5: destination register.
- `wbEn` out 1: register-file write enable.
- `stallOut` out 1: stall IF/ID/EX.
- `pcOut` out 32: PC passed on.
- `instValidOut` out 1: valid passed on.

## Operation
- Pipeline registers capture all `*In` signals when `~stallIn & ~stallOut`.
- The address LSBs are `aluIn[1:0]`, registered as `ofs`.
- Load types (`memCtrl`):
  - 000 lb: sign-extend byte `ofs`.
  - 100 lbu: zero-extend byte `ofs`.
  - 001 lh: sign-extend the halfword at `ofs[1]`.
  - 101 lhu: zero-extend the halfword at `ofs[1]`.
  - 011 lw: full word.
  - 010 lwl: bytes `ofs..0` of the memory word go to the rt high bytes; the remaining low bytes come from rt.
    - ofs=0: `{m[7:0],rt[23:0]}`
    - ofs=1: `{m[15:0],rt[15:0]}`
    - ofs=2: `{m[23:0],rt[7:0]}`
    - ofs=3: `m`
  - 110 lwr:
    - ofs=0: `m`
    - ofs=1: `{rt[31:24],m[31:8]}`
    - ofs=2: `{rt[31:16],m[31:16]}`
    - ofs=3: `{rt[31:8],m[31:24]}`
  - 111: reserved; treated as lw.
- Write-back source (`wbSrc`):
  - 000 ALU
  - 001 load data
  - 010 HI
  - 011 LO
  - 100 PC+8
  - 101–111: ALU
- `wbEn = instValidOut & (wbReg != 0) & (state==RUN | state==DONE)`.
- FSM states RUN, WAIT, DONE:
  - RUN: if the registered `isLoad|isStore` and `~memAck`, go to WAIT and assert `stallOut`. If `memAck` arrives in the same cycle, no stall, and load data is used directly.
  - WAIT: `stallOut=1`. On `memAck`, latch `memRData` into `rdataHold` and go to DONE.
  - DONE: `stallOut=0`. Data comes from `rdataHold`. On the next non-stalled advance, return to RUN. Stay in DONE while `stallIn` is high.
- `memAck` received in RUN without an outstanding access is ignored.
- `flush` while in WAIT is ignored (the access must complete); it applies once the stage advances. `flush` in RUN or DONE clears the control registers normally.

## Timing
- Latency is 1 cycle EX→WB when `memAck` arrives in the cycle the access is in MEM. Each extra wait cycle adds one stall cycle.
- `stallOut` is combinational from state and `memAck`. It must never be asserted in the same cycle that `memAck` is high.
- Reset values:
  - state: RUN
  - `wbReg`: 0
  - `wbEn`: 0
  - `wbData`: 0
  - `stallOut`: 0
  - `pcOut`: 0
  - `instValidOut`: 0
  - `memCtrl`: 011
  - `wbSrc`: 000
  - `rdataHold`: 0
- Reset mid-WAIT returns to RUN and drops the access. Memory must tolerate an orphan ack.
- `stallIn` and `memAck` together in WAIT: data is latched, go to DONE, registers are held.

## Structure
- `cpu_defs` package holds the load-type constants, the `wbSrc` constants, and the FSM state encoding.
- Sub-module `load_align` is purely combinational: inputs memCtrl, ofs, mem word, rt; output 32-bit aligned data.
- Top-level `stage_mem` contains the registers, FSM and write-back mux.

## Test plan
- lb with `aluIn`=…02, `memRData`=0x11_80_33_44, same-cycle ack → `wbData`=0xFFFF_FF80, `wbEn`=1, no stall.
- lhu at ofs=2, `memRData`=0x9ABC_1234 → `wbData`=0x0000_9ABC. lh at ofs=0, `memRData`=0x0000_8001 → 0xFFFF_8001.
- lwl ofs=1, rt=0xAABB_CCDD, m=0x1122_3344 → 0x3344_CCDD. lwr ofs=1, same inputs → 0xAA11_2233.
- Load with `memAck` delayed 3 cycles → `stallOut` high exactly 3 cycles, then correct data. With `stallIn` high for 2 more cycles, data holds in DONE.
- sw with `wbReg`=0 → `wbEn`=0. mfhi with `wbSrc`=010, `hiIn`=0xDEAD_BEEF → `wbData`=0xDEAD_BEEF.
- `rst_n` low during WAIT → next cycle state=RUN, `stallOut`=0, `wbEn`=0. `flush` in RUN → `instValidOut`=0, `wbEn`=0.
